// File: rtl/btn_input_port.sv
// Button input peripheral: per-bit 2-flop synchroniser and debouncer, sticky press events,
// press counter and a small memory-mapped read/write register block.
module btn_input_port #(
  parameter int unsigned NUM_BTNS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btns_raw,
  input  logic [3:0]          addr,
  input  logic                re,
  input  logic                we,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                rvalid,
  output logic                event_pending,
  output logic [NUM_BTNS-1:0] btns_level
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] IdValue = 32'h4254_4E00 | 32'(NUM_BTNS);

  logic [NUM_BTNS-1:0] sync1_q, sync2_q;
  logic [NUM_BTNS-1:0] stable_q, stable_d;
  logic [NUM_BTNS-1:0] stable_dly_q;
  logic [DbW-1:0]      db_cnt_q [NUM_BTNS];
  logic [DbW-1:0]      db_cnt_d [NUM_BTNS];
  logic [NUM_BTNS-1:0] event_q, event_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q;

  logic [NUM_BTNS-1:0] rise;
  logic [CNT_W-1:0]    rise_cnt;
  logic [1:0]          word;
  logic [31:0]         rd_word;
  logic [NUM_BTNS-1:0] rd_clr, wr_clr;

  logic unused_bits;
  assign unused_bits = ^{wdata, addr[1:0]};

  assign word = addr[3:2];
  assign rise = stable_q & ~stable_dly_q;

  // Count consecutive cycles the synchronised input disagrees with the accepted level.
  always_comb begin
    for (int i = 0; i < int'(NUM_BTNS); i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbLast) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end
    end
  end

  always_comb begin
    rise_cnt = '0;
    for (int i = 0; i < int'(NUM_BTNS); i++) begin
      rise_cnt = rise_cnt + CNT_W'(rise[i]);
    end
  end

  always_comb begin
    rd_word = '0;
    case (word)
      2'd0:    rd_word = 32'(stable_q);
      2'd1:    rd_word = 32'(event_q);
      2'd2:    rd_word = 32'(count_q);
      2'd3:    rd_word = IdValue;
      default: rd_word = '0;
    endcase
  end

  // Clears apply first so a same-cycle rise keeps its bit set.
  always_comb begin
    rd_clr  = (re && word == 2'd1) ? event_q : '0;
    wr_clr  = (we && word == 2'd1) ? wdata[NUM_BTNS-1:0] : '0;
    event_d = (event_q & ~(rd_clr | wr_clr)) | rise;
    count_d = (we && word == 2'd2) ? wdata[CNT_W-1:0] : count_q + rise_cnt;
    rdata_d = re ? rd_word : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < int'(NUM_BTNS); i++) begin
        db_cnt_q[i] <= '0;
      end
      event_q      <= '0;
      count_q      <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      sync1_q      <= btns_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < int'(NUM_BTNS); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      event_q      <= event_d;
      count_q      <= count_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= re;
    end
  end

  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign event_pending = |event_q;
  assign btns_level    = stable_q;

endmodule

// File: tb/tb_btn_input_port.sv
// Randomised bench for btn_input_port, checked against a sample-history model of the
// debounce rule plus a register-level model of events, counter and reads.
module tb_btn_input_port;

  localparam int unsigned NB = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned CW = 16;
  localparam logic [31:0] ID = 32'h4254_4E04;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btns_raw = '0;
  logic [3:0]    addr = '0;
  logic          re = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          event_pending;
  logic [NB-1:0] btns_level;

  int errors = 0;
  int checks = 0;

  btn_input_port #(
    .NUM_BTNS(NB),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btns_raw(btns_raw),
    .addr(addr),
    .re(re),
    .we(we),
    .wdata(wdata),
    .rdata(rdata),
    .rvalid(rvalid),
    .event_pending(event_pending),
    .btns_level(btns_level)
  );

  always #5 clk = ~clk;

  // Model state: raw samples (newest first), accepted levels, pending rises, registers.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_stable, m_newrise, m_event;
  logic [CW-1:0] m_count;
  logic [31:0]   m_rdata;
  logic          m_rvalid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int popcount(input logic [NB-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(NB); i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_edge();
    logic [NB-1:0] rise, clr, nxt, h, tmp;
    logic [31:0]   word;
    bit            all_diff;
    if (reset) begin
      hist.delete();
      for (int k = 0; k < int'(DB) + 2; k++) hist.push_front('0);
      m_stable = '0; m_newrise = '0; m_event = '0;
      m_count = '0; m_rdata = '0; m_rvalid = 1'b0;
      return;
    end
    rise = m_newrise;
    case (addr[3:2])
      2'd0: word = 32'(m_stable);
      2'd1: word = 32'(m_event);
      2'd2: word = 32'(m_count);
      default: word = ID;
    endcase
    if (re) m_rdata = word;
    m_rvalid = re;
    clr = '0;
    if (re && addr[3:2] == 2'd1) clr = clr | m_event;
    if (we && addr[3:2] == 2'd1) clr = clr | wdata[NB-1:0];
    m_event = (m_event & ~clr) | rise;
    if (we && addr[3:2] == 2'd2) m_count = wdata[CW-1:0];
    else m_count = m_count + CW'(popcount(rise));
    hist.push_front(btns_raw);
    tmp = hist.pop_back();
    // A level is accepted once the synchronised input (raw two samples back) has
    // disagreed with it for DB consecutive samples.
    nxt = m_stable;
    for (int i = 0; i < int'(NB); i++) begin
      all_diff = 1'b1;
      for (int k = 2; k < int'(DB) + 2; k++) begin
        h = hist[k];
        if (h[i] == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) nxt[i] = ~m_stable[i];
    end
    m_newrise = nxt & ~m_stable;
    m_stable = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level", 32'(btns_level), 32'(m_stable));
    check("pending", 32'(event_pending), 32'(|m_event));
    check("rvalid", 32'(rvalid), 32'(m_rvalid));
    check("rdata", rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [3:0] a);
    addr = a; re = 1'b1;
    step();
    re = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    rd(4'hC); check("id", rdata, ID);
    rd(4'h0); check("rst_level", rdata, 32'h0);
    rd(4'h4); check("rst_event", rdata, 32'h0);
    rd(4'h8); check("rst_count", rdata, 32'h0);

    // Steady press: accepted exactly DB+2 edges after the change.
    btns_raw = 4'b0001;
    idle(int'(DB) + 1);
    check("pre_accept", 32'(btns_level), 32'h0);
    step();
    check("accept", 32'(btns_level), 32'h1);
    step();
    check("ev0_pending", 32'(event_pending), 32'h1);
    rd(4'h8); check("count1", rdata, 32'h1);
    rd(4'h4); check("ev0", rdata, 32'h1);

    // Bounce shorter than the debounce window.
    btns_raw = 4'b0011;
    idle(3);
    btns_raw = 4'b0001;
    idle(10);
    check("bounce_level", 32'(btns_level), 32'h1);
    rd(4'h4); check("bounce_event", rdata, 32'h0);

    // Simultaneous press of buttons 2 and 3.
    btns_raw = 4'b1101;
    idle(int'(DB) + 4);
    rd(4'h8); check("count3", rdata, 32'h3);
    rd(4'h4); check("ev_c", rdata, 32'hC);
    rd(4'h4); check("ev_clr", rdata, 32'h0);
    check("pend_clr", 32'(event_pending), 32'h0);

    // Read EVENT on the very edge a rise on bit 0 sets its event.
    btns_raw = 4'b1100;
    idle(int'(DB) + 4);
    btns_raw = 4'b1101;
    idle(int'(DB) + 2);
    rd(4'h4); check("race_old", rdata, 32'h0);
    check("race_kept", 32'(event_pending), 32'h1);

    // Counter wrap.
    wr(4'h8, 32'h0000_FFFF);
    btns_raw = 4'b1111;
    idle(int'(DB) + 4);
    rd(4'h8); check("wrap", rdata, 32'h0);

    // Reset mid-debounce and mid-read.
    btns_raw = 4'b0000;
    idle(3);
    addr = 4'h4; re = 1'b1;
    reset = 1'b1;
    step();
    re = 1'b0; reset = 1'b0;
    check("rst_lvl2", 32'(btns_level), 32'h0);
    check("rst_rv2", 32'(rvalid), 32'h0);
    rd(4'h8); check("rst_cnt2", rdata, 32'h0);

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(5) == 0) btns_raw = NB'($urandom);
      re = ($urandom_range(9) < 3);
      we = ($urandom_range(9) == 0);
      addr = 4'($urandom);
      wdata = ($urandom_range(3) == 0) ? 32'h0000_FFFE : $urandom;
      reset = ($urandom_range(299) == 0);
      step();
    end
    re = 1'b0; we = 1'b0; reset = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
